// File: rtl/wram_shadow_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wram_shadow_arbiter_pkg
// Shared constants, RV FSM state type and lane-byte helper for the NES WRAM
// shadow arbiter and its BSRAM.
//   WRAM_CPU_BASE : CPU byte address of the 8 kB WRAM window
//   WRAM_RV_BASE  : RV byte address of the 8 kB WRAM window
//   WRAM_AW       : BSRAM byte address width
// -----------------------------------------------------------------------------
package wram_shadow_arbiter_pkg;

  localparam logic [21:0] WRAM_CPU_BASE = 22'h006000;
  localparam logic [22:0] WRAM_RV_BASE  = 23'h066000;
  localparam int          WRAM_AW       = 13;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FWD   = 3'd1,
    WR_LO = 3'd2,
    WR_HI = 3'd3,
    RD_LO = 3'd4,
    RD_HI = 3'd5,
    CAP   = 3'd6
  } rv_state_t;

  // Picks the byte of the 32-bit RV write word that belongs to a lane.
  // word=0 uses the low halfword, word=1 the high halfword.
  function automatic logic [7:0] lane_byte(input logic [31:0] wdata,
                                           input logic        word,
                                           input logic        lane);
    logic [7:0] b;
    case ({word, lane})
      2'b00:   b = wdata[7:0];
      2'b01:   b = wdata[15:8];
      2'b10:   b = wdata[23:16];
      2'b11:   b = wdata[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/wram_shadow_arbiter_bsram.sv
// -----------------------------------------------------------------------------
// wram_bsram_8k
// Single-port 8192x8 synchronous RAM, read-before-write, one access per cycle.
// Contents are never reset so the array maps onto block RAM.
// Ports:
//   i_clk   clock
//   i_en    access enable
//   i_we    write enable (with i_en)
//   i_addr  byte address
//   i_wdata write byte
//   o_q     read byte, valid the cycle after the access (old data on write)
// -----------------------------------------------------------------------------
module wram_bsram_8k
  import wram_shadow_arbiter_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_en,
  input  logic               i_we,
  input  logic [WRAM_AW-1:0] i_addr,
  input  logic [7:0]         i_wdata,
  output logic [7:0]         o_q
);

  localparam int DEPTH = 2 ** WRAM_AW;

  logic [7:0] r_mem [0:DEPTH-1];
  logic [7:0] r_q;

  // RAM port: read old contents, then optionally overwrite.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_q <= r_mem[i_addr];
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/wram_shadow_arbiter.sv
// -----------------------------------------------------------------------------
// wram_shadow_arbiter
// Keeps an 8 kB BSRAM shadow of the NES WRAM window next to the SDRAM arbiter.
// Every write still reaches SDRAM; WRAM-window writes are mirrored into BSRAM
// and WRAM-window reads are served from BSRAM.
// Optional macro WRAM_DIRTY_TRACK_EN adds i_dirty_clr / o_wram_dirty.
// Ports:
//   i_clk, i_resetn          clock, async active-low reset
//   i_wram_load_ongoing      RV gets BSRAM priority
//   i_cpu_*                  CPU address/strobes/data; i_sd_cpu_dout SDRAM data
//   o_cpu_dout               CPU read data (BSRAM on hit, SDRAM otherwise)
//   i_rv_* / o_rv_*          RV request toggle, ack toggle, read data
//   o_sd_rv_req, i_sd_rv_*   forwarded request toggle, SDRAM ack and data
// -----------------------------------------------------------------------------
module wram_shadow_arbiter
  import wram_shadow_arbiter_pkg::*;
#(
  parameter logic [21:0] CPU_WRAM_BASE = WRAM_CPU_BASE,
  parameter logic [22:0] RV_WRAM_BASE  = WRAM_RV_BASE
) (
  input  logic        i_clk,
  input  logic        i_resetn,
`ifdef WRAM_DIRTY_TRACK_EN
  input  logic        i_dirty_clr,
  output logic        o_wram_dirty,
`endif
  input  logic        i_wram_load_ongoing,
  input  logic [21:0] i_cpu_addr,
  input  logic        i_cpu_read,
  input  logic        i_cpu_write,
  input  logic [7:0]  i_cpu_din,
  input  logic [7:0]  i_sd_cpu_dout,
  output logic [7:0]  o_cpu_dout,
  input  logic [22:0] i_rv_addr,
  input  logic        i_rv_word,
  input  logic [31:0] i_rv_wdata,
  input  logic [1:0]  i_rv_ds,
  input  logic [3:0]  i_rv_wstrb,
  input  logic        i_rv_req,
  output logic        o_rv_req_ack,
  output logic [15:0] o_rv_dout,
  output logic        o_sd_rv_req,
  input  logic        i_sd_rv_req_ack,
  input  logic [15:0] i_sd_rv_dout
);

  rv_state_t r_state, w_state_nxt;

  logic        r_rv_req_ack, r_sd_rv_req;
  logic [15:0] r_rv_dout;
  logic [10:0] r_rv_off;
  logic        r_rv_word, r_rv_wr, r_rv_hit, r_lo_fresh;
  logic [1:0]  r_rv_ds;
  logic [31:0] r_rv_wdata;
  logic [7:0]  r_rv_lo;
  logic        r_cpu_hit_q, r_cpu_rd_pend;
  logic [7:0]  r_cpu_rd_q;

  logic w_cpu_hit, w_rv_hit, w_cpu_acc, w_rv_pending;
  logic w_rv_port_req, w_rv_port_we, w_rv_lane, w_rv_grant, w_cpu_grant;
  logic w_latch, w_ack_tgl, w_sd_tgl, w_ld_sd, w_ld_cap;
  logic               w_ram_en, w_ram_we;
  logic [WRAM_AW-1:0] w_ram_addr;
  logic [7:0]         w_ram_wdata, w_ram_q;
  logic               w_unused;

  // Word-aligned RV address: the byte bits come from word/lane instead.
  assign w_unused = &{1'b0, i_rv_addr[1:0]};

  assign w_cpu_hit    = (i_cpu_addr[21:13] == CPU_WRAM_BASE[21:13]);
  assign w_rv_hit     = (i_rv_addr[22:13] == RV_WRAM_BASE[22:13]);
  assign w_cpu_acc    = w_cpu_hit & (i_cpu_read | i_cpu_write);
  assign w_rv_pending = (i_rv_req != r_rv_req_ack);

  // RV wants the port in read states, and in write states whose lane strobe is set.
  assign w_rv_port_req = (r_state == RD_LO) || (r_state == RD_HI) ||
                         ((r_state == WR_LO) && r_rv_ds[0]) ||
                         ((r_state == WR_HI) && r_rv_ds[1]);
  assign w_rv_port_we  = (r_state == WR_LO) || (r_state == WR_HI);
  assign w_rv_lane     = (r_state == WR_HI) || (r_state == RD_HI);
  // CPU wins by default; a save-state load hands priority to RV.
  assign w_rv_grant    = w_rv_port_req & (~w_cpu_acc | i_wram_load_ongoing);
  assign w_cpu_grant   = w_cpu_acc & ~w_rv_grant;

  // BSRAM port mux: the granted requester drives address, enable and data.
  always_comb begin
    w_ram_en    = w_rv_grant | w_cpu_grant;
    w_ram_we    = 1'b0;
    w_ram_addr  = i_cpu_addr[WRAM_AW-1:0];
    w_ram_wdata = i_cpu_din;
    if (w_rv_grant) begin
      w_ram_we    = w_rv_port_we;
      w_ram_addr  = {r_rv_off, r_rv_word, w_rv_lane};
      w_ram_wdata = lane_byte(r_rv_wdata, r_rv_word, w_rv_lane);
    end else begin
      w_ram_we    = w_cpu_grant & i_cpu_write;
    end
  end

  wram_bsram_8k u_bsram (
    .i_clk   (i_clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_q     (w_ram_q)
  );

  // RV FSM state register.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RV FSM next state and per-cycle actions.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_ack_tgl   = 1'b0;
    w_sd_tgl    = 1'b0;
    w_ld_sd     = 1'b0;
    w_ld_cap    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rv_pending) begin
          w_latch = 1'b1;
          if (!w_rv_hit || (i_rv_wstrb != 4'b0000)) begin
            w_sd_tgl    = 1'b1;
            w_state_nxt = FWD;
          end else begin
            w_state_nxt = RD_LO;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FWD: begin
        if (i_sd_rv_req_ack == r_sd_rv_req) begin
          w_ld_sd = ~r_rv_wr;
          if (r_rv_hit && r_rv_wr) begin
            w_state_nxt = WR_LO;
          end else begin
            w_ack_tgl   = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = FWD;
        end
      end
      WR_LO: begin
        if (!r_rv_ds[0] || w_rv_grant) begin
          w_state_nxt = WR_HI;
        end else begin
          w_state_nxt = WR_LO;
        end
      end
      WR_HI: begin
        if (!r_rv_ds[1] || w_rv_grant) begin
          w_ack_tgl   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WR_HI;
        end
      end
      RD_LO: begin
        if (w_rv_grant) begin
          w_state_nxt = RD_HI;
        end else begin
          w_state_nxt = RD_LO;
        end
      end
      RD_HI: begin
        if (w_rv_grant) begin
          w_state_nxt = CAP;
        end else begin
          w_state_nxt = RD_HI;
        end
      end
      CAP: begin
        w_ld_cap    = 1'b1;
        w_ack_tgl   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // RV request latch, toggles and read data assembly.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_rv_req_ack <= 1'b0;
      r_sd_rv_req  <= 1'b0;
      r_rv_dout    <= 16'h0000;
      r_rv_off     <= 11'h000;
      r_rv_word    <= 1'b0;
      r_rv_wr      <= 1'b0;
      r_rv_hit     <= 1'b0;
      r_rv_ds      <= 2'b00;
      r_rv_wdata   <= 32'h0000_0000;
      r_rv_lo      <= 8'h00;
      r_lo_fresh   <= 1'b0;
    end else begin
      r_rv_req_ack <= r_rv_req_ack ^ w_ack_tgl;
      r_sd_rv_req  <= r_sd_rv_req ^ w_sd_tgl;
      if (w_latch) begin
        r_rv_off   <= i_rv_addr[12:2];
        r_rv_word  <= i_rv_word;
        r_rv_wr    <= (i_rv_wstrb != 4'b0000);
        r_rv_hit   <= w_rv_hit;
        r_rv_ds    <= i_rv_ds;
        r_rv_wdata <= i_rv_wdata;
      end
      // q holds the low byte only in the cycle right after the RD_LO access;
      // RD_HI may stall while the CPU uses the port.
      r_lo_fresh <= (r_state == RD_LO) & w_rv_grant;
      if (r_lo_fresh) begin
        r_rv_lo <= w_ram_q;
      end
      if (w_ld_sd) begin
        r_rv_dout <= i_sd_rv_dout;
      end else if (w_ld_cap) begin
        r_rv_dout <= {w_ram_q, r_rv_lo};
      end
    end
  end

  // CPU read return: hit/miss flag and BSRAM hold register.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_cpu_hit_q   <= 1'b0;
      r_cpu_rd_pend <= 1'b0;
      r_cpu_rd_q    <= 8'h00;
    end else begin
      if (i_cpu_read) begin
        r_cpu_hit_q <= w_cpu_hit;
      end
      // A read that lost the port leaves the hold register untouched.
      r_cpu_rd_pend <= w_cpu_grant & i_cpu_read;
      if (r_cpu_rd_pend) begin
        r_cpu_rd_q <= w_ram_q;
      end
    end
  end

`ifdef WRAM_DIRTY_TRACK_EN
  logic r_wram_dirty;

  // Dirty flag: any performed BSRAM write sets it, and a set beats a clear.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wram_dirty <= 1'b0;
    end else if (w_ram_en && w_ram_we) begin
      r_wram_dirty <= 1'b1;
    end else if (i_dirty_clr) begin
      r_wram_dirty <= 1'b0;
    end
  end

  assign o_wram_dirty = r_wram_dirty;
`endif

  assign o_cpu_dout   = r_cpu_hit_q ? r_cpu_rd_q : i_sd_cpu_dout;
  assign o_rv_req_ack = r_rv_req_ack;
  assign o_sd_rv_req  = r_sd_rv_req;
  assign o_rv_dout    = r_rv_dout;

endmodule

// File: tb/tb_wram_shadow_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wram_shadow_arbiter
// Scoreboard bench: expected read data is computed from a byte-array model of
// the WRAM shadow, queued when a read is issued and compared on return.
// A small SDRAM responder acks forwarded RV requests three cycles later.
// -----------------------------------------------------------------------------
module tb_wram_shadow_arbiter;

  logic        clk;
  logic        resetn;
  logic        load;
  logic [21:0] cpu_addr;
  logic        cpu_read, cpu_write;
  logic [7:0]  cpu_din, sd_cpu_dout, cpu_dout;
  logic [22:0] rv_addr;
  logic        rv_word;
  logic [31:0] rv_wdata;
  logic [1:0]  rv_ds;
  logic [3:0]  rv_wstrb;
  logic        rv_req, rv_req_ack;
  logic [15:0] rv_dout;
  logic        sd_rv_req, sd_rv_req_ack;
  logic [15:0] sd_rv_dout;

  logic [7:0]  shadow [0:8191];
  logic [31:0] q_cpu [$];
  logic [31:0] q_rv [$];
  int          n_asserts;
  int          n_fail;
  int          sd_toggles;

  wram_shadow_arbiter dut (
    .i_clk               (clk),
    .i_resetn            (resetn),
    .i_wram_load_ongoing (load),
    .i_cpu_addr          (cpu_addr),
    .i_cpu_read          (cpu_read),
    .i_cpu_write         (cpu_write),
    .i_cpu_din           (cpu_din),
    .i_sd_cpu_dout       (sd_cpu_dout),
    .o_cpu_dout          (cpu_dout),
    .i_rv_addr           (rv_addr),
    .i_rv_word           (rv_word),
    .i_rv_wdata          (rv_wdata),
    .i_rv_ds             (rv_ds),
    .i_rv_wstrb          (rv_wstrb),
    .i_rv_req            (rv_req),
    .o_rv_req_ack        (rv_req_ack),
    .o_rv_dout           (rv_dout),
    .o_sd_rv_req         (sd_rv_req),
    .i_sd_rv_req_ack     (sd_rv_req_ack),
    .i_sd_rv_dout        (sd_rv_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // SDRAM arbiter model: acks a forwarded request three cycles after it toggles.
  initial begin : sd_model
    int   cnt;
    logic prev;
    cnt = 0;
    prev = 1'b0;
    sd_toggles = 0;
    sd_rv_req_ack = 1'b0;
    sd_rv_dout = 16'hC0DE;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        sd_rv_req_ack = 1'b0;
        cnt = 0;
        prev = 1'b0;
      end else begin
        if (sd_rv_req !== prev) begin
          sd_toggles++;
          prev = sd_rv_req;
        end
        if (sd_rv_req !== sd_rv_req_ack) begin
          cnt++;
          if (cnt == 3) begin
            sd_rv_req_ack = sd_rv_req;
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  task automatic cpu_wr(input logic [21:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    cpu_addr = addr; cpu_din = data; cpu_write = 1'b1;
    if (addr[21:13] == 9'h003) shadow[addr[12:0]] = data;
    @(posedge clk); #1;
    cpu_write = 1'b0;
  endtask

  task automatic cpu_rd(input string tag, input logic [21:0] addr, input logic [7:0] sd);
    @(posedge clk); #1;
    cpu_addr = addr; cpu_read = 1'b1; sd_cpu_dout = sd;
    q_cpu.push_back((addr[21:13] == 9'h003) ? {24'h0, shadow[addr[12:0]]} : {24'h0, sd});
    @(posedge clk); #1;
    cpu_read = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check_eq(tag, {24'h0, cpu_dout}, q_cpu.pop_front());
  endtask

  // Issues one RV request and waits (bounded) for its ack; lat counts cycles.
  task automatic rv_xfer(input string tag, input logic [22:0] addr, input logic word,
                         input logic [31:0] wdata, input logic [1:0] ds,
                         input logic [3:0] wstrb, output int lat);
    @(posedge clk); #1;
    rv_addr = addr; rv_word = word; rv_wdata = wdata; rv_ds = ds; rv_wstrb = wstrb;
    rv_req = ~rv_req;
    lat = 0;
    while (rv_req_ack !== rv_req && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_ack"}, {31'h0, rv_req_ack}, {31'h0, rv_req});
  endtask

  // RV hit write to offset 0x30 colliding with a CPU write in the WR_LO cycle.
  task automatic rv_collide(input string tag, input logic ld, input logic [12:0] cpu_off,
                            input logic [7:0] cpu_val, input logic [7:0] rv_val,
                            output int lat);
    logic old_sd;
    int   guard;
    @(posedge clk); #1;
    load = ld;
    rv_addr = 23'h066030; rv_word = 1'b0; rv_wdata = {24'h0, rv_val};
    rv_ds = 2'b01; rv_wstrb = 4'b0001;
    old_sd = sd_rv_req;
    rv_req = ~rv_req;
    guard = 0;
    while (sd_rv_req === old_sd && guard < 50) begin @(negedge clk); guard++; end
    while (sd_rv_req_ack !== sd_rv_req && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    cpu_addr = 22'h006000 + {9'h000, cpu_off}; cpu_din = cpu_val; cpu_write = 1'b1;
    @(posedge clk); #1;
    cpu_write = 1'b0;
    lat = 0;
    while (rv_req_ack !== rv_req && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_ack"}, {31'h0, rv_req_ack}, {31'h0, rv_req});
    load = 1'b0;
    if (!ld) shadow[cpu_off] = cpu_val;
    shadow[13'h0030] = rv_val;
  endtask

  initial begin : main
    int lat, lat0, lat1, sd0;
    n_asserts = 0; n_fail = 0;
    resetn = 1'b0; load = 1'b0;
    cpu_addr = 22'h0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_din = 8'h00;
    sd_cpu_dout = 8'h5A;
    rv_addr = 23'h0; rv_word = 1'b0; rv_wdata = 32'h0; rv_ds = 2'b00;
    rv_wstrb = 4'b0000; rv_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", {31'h0, rv_req_ack}, 32'h0);
    check_eq("rst_sd_req", {31'h0, sd_rv_req}, 32'h0);
    check_eq("rst_rv_dout", {16'h0, rv_dout}, 32'h0);
    check_eq("rst_cpu_dout", {24'h0, cpu_dout}, 32'h5A);
    resetn = 1'b1;

    // CPU shadow round trip and a miss read.
    cpu_wr(22'h006010, 8'hA5);
    cpu_rd("cpu_hit_a5", 22'h006010, 8'h00);
    cpu_rd("cpu_miss_3c", 22'h008000, 8'h3C);

    // RV hit read of CPU-written bytes: served locally, minimum latency.
    cpu_wr(22'h006010, 8'h11);
    cpu_wr(22'h006011, 8'h22);
    sd0 = sd_toggles;
    q_rv.push_back({16'h0, shadow[13'h11], shadow[13'h10]});
    rv_xfer("rv_hit_rd", 23'h066010, 1'b0, 32'h0, 2'b11, 4'b0000, lat);
    check_eq("rv_hit_rd_dout", {16'h0, rv_dout}, q_rv.pop_front());
    check_eq("rv_hit_rd_lat", lat, 32'd4);
    check_eq("rv_hit_rd_no_sd", sd_toggles - sd0, 32'd0);

    // RV hit write, low lane only: SDRAM first, then BSRAM.
    sd0 = sd_toggles;
    rv_xfer("rv_hit_wr", 23'h066010, 1'b0, 32'h0000BEEF, 2'b01, 4'b0011, lat);
    shadow[13'h10] = 8'hEF;
    check_eq("rv_hit_wr_sd", sd_toggles - sd0, 32'd1);
    cpu_rd("cpu_after_wr_lo", 22'h006010, 8'h00);
    cpu_rd("cpu_after_wr_hi", 22'h006011, 8'h00);

    // RV miss read returns SDRAM data.
    sd0 = sd_toggles;
    q_rv.push_back(32'h0000C0DE);
    rv_xfer("rv_miss_rd", 23'h000100, 1'b0, 32'h0, 2'b11, 4'b0000, lat);
    check_eq("rv_miss_rd_dout", {16'h0, rv_dout}, q_rv.pop_front());
    check_eq("rv_miss_rd_sd", sd_toggles - sd0, 32'd1);

    // Upper halfword (word=1) write and read back.
    rv_xfer("rv_w1_wr", 23'h066020, 1'b1, 32'hA1B2_0000, 2'b11, 4'b1100, lat);
    shadow[13'h22] = 8'hB2;
    shadow[13'h23] = 8'hA1;
    q_rv.push_back({16'h0, shadow[13'h23], shadow[13'h22]});
    rv_xfer("rv_w1_rd", 23'h066020, 1'b1, 32'h0, 2'b11, 4'b0000, lat);
    check_eq("rv_w1_rd_dout", {16'h0, rv_dout}, q_rv.pop_front());
    cpu_rd("cpu_w1_lo", 22'h006022, 8'h00);

    // Port collisions with and without save-state load priority.
    rv_collide("coll_ld0", 1'b0, 13'h0030, 8'h77, 8'h55, lat0);
    cpu_rd("coll_ld0_byte", 22'h006030, 8'h00);
    rv_collide("coll_ld1", 1'b1, 13'h0030, 8'h77, 8'h66, lat1);
    cpu_rd("coll_ld1_byte", 22'h006030, 8'h00);
    check_eq("coll_lat_diff", lat0, lat1 + 1);
    cpu_wr(22'h006031, 8'h44);
    rv_collide("coll_drop", 1'b1, 13'h0031, 8'h99, 8'h12, lat);
    cpu_rd("coll_drop_byte", 22'h006031, 8'h00);

    // Reset in RD_HI aborts the request.
    @(posedge clk); #1;
    rv_addr = 23'h066010; rv_word = 1'b0; rv_ds = 2'b11; rv_wstrb = 4'b0000;
    rv_req = ~rv_req;
    @(posedge clk);
    @(posedge clk); #1;
    resetn = 1'b0;
    rv_req = 1'b0;
    #3;
    check_eq("abort_ack", {31'h0, rv_req_ack}, 32'h0);
    check_eq("abort_sd_req", {31'h0, sd_rv_req}, 32'h0);
    check_eq("abort_rv_dout", {16'h0, rv_dout}, 32'h0);
    check_eq("abort_cpu_dout", {24'h0, cpu_dout}, {24'h0, sd_cpu_dout});
    @(posedge clk); #1;
    resetn = 1'b1;
    q_rv.push_back({16'h0, shadow[13'h11], shadow[13'h10]});
    rv_xfer("post_rst_rd", 23'h066010, 1'b0, 32'h0, 2'b11, 4'b0000, lat);
    check_eq("post_rst_dout", {16'h0, rv_dout}, q_rv.pop_front());
    check_eq("post_rst_lat", lat, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/wram_shadow_arbiter.md
Name: wram_shadow_arbiter

Overview:
- Sits directly upstream of the SDRAM arbiter, on the CPU data-return path and the RV request/ack path.
- Holds an 8 kB BSRAM shadow of the NES WRAM window.
- All writes (CPU and RV) still reach SDRAM. Every write that hits the WRAM window is also mirrored into the BSRAM.
- WRAM-window reads are served from the BSRAM. All other reads return SDRAM data unchanged.

Parameters:
CPU_WRAM_BASE, 22'h006000, CPU byte address of WRAM start (8 kB aligned)
RV_WRAM_BASE, 23'h066000, RV byte address of WRAM start (8 kB aligned)
WRAM_AW, 13, BSRAM address width (2^13 bytes)

Ports:
i_clk  in  1  system clock
i_resetn  in  1  asynchronous active-low reset
i_wram_load_ongoing  in  1  RV owns BSRAM priority (save-state load)
i_cpu_addr  in  22  CPU SDRAM byte address
i_cpu_read  in  1  CPU read strobe, 1-cycle pulse
i_cpu_write  in  1  CPU write strobe, 1-cycle pulse
i_cpu_din  in  8  CPU write data
i_sd_cpu_dout  in  8  CPU read data from SDRAM arbiter
o_cpu_dout  out  8  CPU read data to core
i_rv_addr  in  23  RV byte address
i_rv_word  in  1  selects upper 16-bit half of the 32-bit word
i_rv_wdata  in  32  RV write data
i_rv_ds  in  2  byte strobes: [0]=low byte, [1]=high byte
i_rv_wstrb  in  4  nonzero = write
i_rv_req  in  1  RV request toggle
o_rv_req_ack  out  1  RV ack toggle
o_rv_dout  out  16  RV read data
o_sd_rv_req  out  1  request toggle to SDRAM arbiter
i_sd_rv_req_ack  in  1  ack toggle from SDRAM arbiter
i_sd_rv_dout  in  16  RV read data from SDRAM arbiter

Behaviour:
- RV address, data, ds and wstrb pass to the SDRAM arbiter outside this block. Only req, ack and dout go through this block.
- Hit decode:
  - CPU hit: i_cpu_addr[21:13]==CPU_WRAM_BASE[21:13]; offset i_cpu_addr[12:0].
  - RV hit: i_rv_addr[22:13]==RV_WRAM_BASE[22:13]; lane offset {i_rv_addr[12:2],i_rv_word,lane}.
  - Lane byte: lane0 = wdata[7:0] or [23:16] (word=1); lane1 = wdata[15:8] or [31:24].
- BSRAM: single port, byte-wide, 1-cycle synchronous read. One access per cycle.
- Port grant:
  - Normally a CPU hit (read or write) wins the port. RV retries next cycle.
  - If i_wram_load_ongoing=1, a pending RV access wins. A losing CPU write is dropped from BSRAM only. A losing CPU read returns the current hold register value.
- CPU read return:
  - On a granted CPU read hit, the BSRAM q is captured into cpu_rd_q the next cycle.
  - cpu_hit_q records the hit/miss of the last i_cpu_read.
  - o_cpu_dout = cpu_hit_q ? cpu_rd_q : i_sd_cpu_dout.
- RV FSM. A request is pending when i_rv_req != o_rv_req_ack. The request is latched in IDLE.
  - IDLE -> FWD: on a miss, or on a hit write. o_sd_rv_req toggles in the same cycle.
  - FWD: wait until i_sd_rv_req_ack==o_sd_rv_req. On a read, latch i_sd_rv_dout into o_rv_dout.
    - Hit write: go to WR_LO.
    - Otherwise: toggle o_rv_req_ack, go to IDLE.
  - WR_LO / WR_HI: write the lane when its ds bit is set and the port is granted. Skip the lane if its ds bit is clear. After the last lane, toggle ack and go to IDLE.
  - RD_LO -> RD_HI -> CAP: hit read; each state waits for port grant.
    - CAP assembles o_rv_dout={hi,lo}, toggles ack, goes to IDLE.
    - No SDRAM request is issued.
- Ack ordering:
  - Ack toggles only after all work for the request completes.
  - Minimum latency for a hit read: 4 cycles from the request toggle.
  - A new toggle seen while busy is held pending until IDLE.
- Reset (asynchronous, i_resetn=0):
  - Outputs: o_rv_req_ack=0, o_sd_rv_req=0, o_rv_dout=0, o_cpu_dout follows SDRAM data.
  - Internal: cpu_hit_q=0, cpu_rd_q=0, FSM=IDLE.
  - Any in-flight operation is aborted. BSRAM contents are not cleared.

Optional Feature:
- Macro WRAM_DIRTY_TRACK_EN.
- Defined: adds port i_dirty_clr (in, 1) and port o_wram_dirty (out, 1).
  - o_wram_dirty is set on any BSRAM write actually performed by the CPU or RV.
  - i_dirty_clr clears it. A set in the same cycle as a clear wins.
  - Reset value 0.
- Undefined: neither port exists; no logic is generated.

Decomposition:
- configPackage gains:
  - WRAM_CPU_BASE and WRAM_RV_BASE constants.
  - WRAM_AW.
  - An rv_state_t enum: IDLE, FWD, WR_LO, WR_HI, RD_LO, RD_HI, CAP.
- Sub-module wram_bsram_8k: single-port 8192x8 synchronous RAM, read-before-write, used for BSRAM inference.

Test Plan:
- CPU write 0xA5 to 0x006010, then CPU read 0x006010 -> o_cpu_dout=0xA5; SDRAM also saw the write.
- CPU read 0x008000 (miss) with i_sd_cpu_dout=0x3C -> o_cpu_dout=0x3C.
- RV hit read 0x066010, word=0, ds=2'b11, after CPU wrote 0x11/0x22 to 0x006010/0x006011 -> o_rv_dout=0x2211 and ack toggles; o_sd_rv_req never toggles.
- RV hit write wdata=0xBEEF, ds=2'b01 -> SDRAM req toggled; after SDRAM ack, only 0xEF is written. The CPU then reads 0xEF from low offset 0x10 and the old value from high offset 0x11; ack follows the SDRAM ack.
- Simultaneous CPU write hit and RV hit write to the same byte:
  - load=0: CPU value lands first, then RV overwrites.
  - load=1: CPU BSRAM write dropped; final byte is the RV value.
- Reset asserted in RD_HI -> ack=0, FSM=IDLE; after release, a fresh request completes normally.
